puzzle_ctrl: RTL and testbench

Game-state controller for the 2x2 sliding image puzzle. It produces the 12-bit tile-arrangement word `img_nums` that the VGA tile renderer reads each frame. It turns four debounced direction buttons and a start button into legal blank-tile moves, shuffles the board with an LFSR, counts moves and flags a solved board. It runs in the system clock domain; the renderer samples `img_nums` asynchronously to frame timing, so `img_nums` must only change as a single registered update.

---
 rtl/puzzle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_puzzle_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_ctrl.sv
// Game-state controller for the 2x2 sliding image puzzle: debounced buttons,
// LFSR shuffle, legal blank moves, move counting and solved detection.
module puzzle_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SHUFFLE_MOVES   = 32,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    output logic [11:0] img_nums,
    output logic        solved,
    output logic        busy,
    output logic [9:0]  move_cnt
);

    localparam int unsigned NBTN    = 5;
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SH_W    = $clog2(SHUFFLE_MOVES + 1);
    localparam int unsigned B_START = 0;
    localparam int unsigned B_UP    = 1;
    localparam int unsigned B_DOWN  = 2;
    localparam int unsigned B_LEFT  = 3;
    localparam int unsigned B_RIGHT = 4;
    localparam logic [11:0] SOLVED  = 12'h054;
    localparam logic [2:0]  BLANK   = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_SHUFFLE, S_PLAY, S_WIN} state_t;

    // Field index: 0=A (top-left), 1=B, 2=C, 3=D. Bit 1 = bottom row, bit 0 = right column.
    function automatic logic [1:0] blank_pos(input logic [11:0] w);
        blank_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w[3*(3-i) +: 3] == BLANK) blank_pos = 2'(i);
        end
    endfunction

    function automatic logic [11:0] swap_fields(input logic [11:0] w, input logic [1:0] a,
                                                input logic [1:0] b);
        logic [2:0] f [4];
        logic [2:0] tmp;
        for (int i = 0; i < 4; i++) f[i] = w[3*(3-i) +: 3];
        tmp  = f[a];
        f[a] = f[b];
        f[b] = tmp;
        return {f[0], f[1], f[2], f[3]};
    endfunction

    logic [NBTN-1:0] raw_c;
    logic [NBTN-1:0] sync1_q, sync2_q, level_q, press_q;
    logic [DB_W-1:0] db_cnt_q [NBTN];

    assign raw_c = {btn_right, btn_left, btn_down, btn_up, btn_start};

    // Two-flop synchronizer, stability counter and rising-edge press pulse per button
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            for (int i = 0; i < NBTN; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_q[i] <= '0;
                    level_q[i]  <= sync2_q[i];
                    press_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    state_t          state_q, state_d;
    logic [11:0]     img_q, img_d;
    logic [9:0]      cnt_q, cnt_d;
    logic [SH_W-1:0] shuf_q, shuf_d;
    logic            solved_q, solved_d;
    logic            busy_q, busy_d;
    logic [15:0]     lfsr_q;
    logic [1:0]      blank_c, dir_tgt_c;
    logic            dir_legal_c;

    assign blank_c = blank_pos(img_q);

    // Only the highest-priority direction is considered; an illegal one is dropped
    always_comb begin
        dir_legal_c = 1'b0;
        dir_tgt_c   = blank_c;
        if (press_q[B_UP]) begin
            dir_legal_c = blank_c[1];
            dir_tgt_c   = blank_c ^ 2'b10;
        end else if (press_q[B_DOWN]) begin
            dir_legal_c = ~blank_c[1];
            dir_tgt_c   = blank_c ^ 2'b10;
        end else if (press_q[B_LEFT]) begin
            dir_legal_c = blank_c[0];
            dir_tgt_c   = blank_c ^ 2'b01;
        end else if (press_q[B_RIGHT]) begin
            dir_legal_c = ~blank_c[0];
            dir_tgt_c   = blank_c ^ 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        cnt_d   = cnt_q;
        shuf_d  = shuf_q;
        unique case (state_q)
            S_IDLE, S_WIN: begin
                if (press_q[B_START]) begin
                    state_d = S_SHUFFLE;
                    cnt_d   = '0;
                    shuf_d  = '0;
                end
            end
            S_SHUFFLE: begin
                img_d = swap_fields(img_q, blank_c, blank_c ^ (lfsr_q[0] ? 2'b10 : 2'b01));
                if (shuf_q != '1) shuf_d = shuf_q + SH_W'(1);
                if ((shuf_d >= SH_W'(SHUFFLE_MOVES)) && (img_d != SOLVED)) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (press_q[B_START]) begin
                    state_d = S_SHUFFLE;
                    cnt_d   = '0;
                    shuf_d  = '0;
                end else if (dir_legal_c) begin
                    img_d = swap_fields(img_q, blank_c, dir_tgt_c);
                    if (cnt_q != '1) cnt_d = cnt_q + 10'd1;
                    if (img_d == SOLVED) state_d = S_WIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        solved_d = (state_d == S_IDLE) || (state_d == S_WIN);
        busy_d   = (state_d == S_SHUFFLE);
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            img_q    <= SOLVED;
            cnt_q    <= '0;
            shuf_q   <= '0;
            solved_q <= 1'b1;
            busy_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            img_q    <= img_d;
            cnt_q    <= cnt_d;
            shuf_q   <= shuf_d;
            solved_q <= solved_d;
            busy_q   <= busy_d;
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign img_nums = img_q;
    assign solved   = solved_q;
    assign busy     = busy_q;
    assign move_cnt = cnt_q;

endmodule

// File: tb/tb_puzzle_ctrl.sv
// Scoreboard bench for puzzle_ctrl: stimulus queues expected output updates,
// a monitor pops one entry for every observed change of the outputs.
module tb_puzzle_ctrl;

    localparam int unsigned DB       = 4;
    localparam int unsigned SM       = 8;
    localparam logic [11:0] SOLVED_W = 12'h054;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        btn_up, btn_down, btn_left, btn_right, btn_start;
    logic [11:0] img_nums;
    logic        solved, busy;
    logic [9:0]  move_cnt;

    puzzle_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SHUFFLE_MOVES  (SM),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_start(btn_start),
        .img_nums (img_nums),
        .solved   (solved),
        .busy     (busy),
        .move_cnt (move_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [11:0] img;
        logic        solved;
        logic        busy;
        logic [9:0]  cnt;
        logic [7:0]  tag;
    } exp_t;

    exp_t        exp_q [$];
    int          n_checks;
    int          n_fail;
    logic [7:0]  tag_n;
    logic [11:0] img_m;
    logic [9:0]  cnt_m;
    logic        play_m;
    logic [15:0] lfsr_m;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge sys_clk or negedge rst) begin
        if (!rst) lfsr_m <= 16'hACE1;
        else      lfsr_m <= lfsr_step(lfsr_m);
    end

    function automatic int blank_m(input logic [11:0] w);
        int p;
        p = -1;
        for (int i = 0; i < 4; i++) if (w[11-3*i -: 3] == 3'b100) p = i;
        return p;
    endfunction

    function automatic int n_blank(input logic [11:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (w[11-3*i -: 3] == 3'b100) n++;
        return n;
    endfunction

    function automatic logic [11:0] swap_m(input logic [11:0] w, input int a, input int b);
        logic [11:0] r;
        logic [2:0]  fa, fb;
        r  = w;
        fa = w[11-3*a -: 3];
        fb = w[11-3*b -: 3];
        r[11-3*a -: 3] = fb;
        r[11-3*b -: 3] = fa;
        return r;
    endfunction

    // dir: 0 up, 1 down, 2 left, 3 right; returns target field or -1 if illegal
    function automatic int tgt_of(input int dir, input int pos);
        case (dir)
            0:       return (pos == 2) ? 0 : (pos == 3) ? 1 : -1;
            1:       return (pos == 0) ? 2 : (pos == 1) ? 3 : -1;
            2:       return (pos == 1) ? 0 : (pos == 3) ? 2 : -1;
            default: return (pos == 0) ? 1 : (pos == 2) ? 3 : -1;
        endcase
    endfunction

    function automatic int cw_dir(input int pos);
        case (pos)
            0: return 3; 1: return 1; 2: return 0; default: return 2;
        endcase
    endfunction

    function automatic int ccw_dir(input int pos);
        case (pos)
            0: return 1; 1: return 2; 2: return 3; default: return 0;
        endcase
    endfunction

    function automatic int shuffle_nb(input int pos, input logic vert);
        case (pos)
            0: return vert ? 2 : 1;
            1: return vert ? 3 : 0;
            2: return vert ? 0 : 3;
            default: return vert ? 1 : 2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] img, input logic s, input logic b,
                            input logic [9:0] c);
        exp_t e;
        e.img = img; e.solved = s; e.busy = b; e.cnt = c; e.tag = tag_n;
        tag_n = tag_n + 8'd1;
        exp_q.push_back(e);
    endtask

    logic [23:0] mon_last, mon_now;
    logic        mon_have;
    exp_t        mon_e;

    initial begin : monitor
        mon_have = 1'b0;
        forever begin
            @(negedge sys_clk);
            mon_now = {img_nums, solved, busy, move_cnt};
            if (mon_have && (mon_now !== mon_last)) begin
                check("one_blank", 32'(n_blank(img_nums)), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: got img=%h solved=%b busy=%b cnt=%0d, expected no change",
                             img_nums, solved, busy, move_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("upd%0d_img", mon_e.tag), 32'(img_nums), 32'(mon_e.img));
                    check($sformatf("upd%0d_solved", mon_e.tag), 32'(solved), 32'(mon_e.solved));
                    check($sformatf("upd%0d_busy", mon_e.tag), 32'(busy), 32'(mon_e.busy));
                    check($sformatf("upd%0d_cnt", mon_e.tag), 32'(move_cnt), 32'(mon_e.cnt));
                end
            end
            mon_last = mon_now;
            mon_have = 1'b1;
        end
    end

    // dirs = {up, down, left, right}
    task automatic press(input logic [3:0] dirs);
        int dir, pos, t;
        dir = -1;
        for (int i = 0; i < 4; i++) if (dirs[3-i] && dir < 0) dir = i;
        if (dir >= 0 && play_m) begin
            pos = blank_m(img_m);
            t   = tgt_of(dir, pos);
            if (t >= 0) begin
                img_m = swap_m(img_m, pos, t);
                if (cnt_m != 10'h3ff) cnt_m = cnt_m + 10'd1;
                if (img_m == SOLVED_W) play_m = 1'b0;
                push_exp(img_m, ~play_m, 1'b0, cnt_m);
            end
        end
        @(negedge sys_clk);
        {btn_up, btn_down, btn_left, btn_right} = dirs;
        repeat (8) @(negedge sys_clk);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic do_start(input bit reset_mid);
        logic [15:0] lf;
        logic [11:0] im;
        int          n, waited;
        bit          done;
        push_exp(img_m, 1'b0, 1'b1, 10'd0);
        @(negedge sys_clk);
        btn_start = 1'b1;
        waited = 0;
        do begin
            @(negedge sys_clk);
            waited++;
        end while (!busy && waited < 20);
        btn_start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        lf = lfsr_m; im = img_m; n = 0; done = 0;
        while (!done && n < 200) begin
            im   = swap_m(im, blank_m(im), shuffle_nb(blank_m(im), lf[0]));
            lf   = lfsr_step(lf);
            n++;
            done = (n >= SM) && (im != SOLVED_W);
            if (!reset_mid || n <= 3) push_exp(im, 1'b0, ~done, 10'd0);
        end
        if (reset_mid) begin
            push_exp(SOLVED_W, 1'b1, 1'b0, 10'd0);
            repeat (3) @(negedge sys_clk);
            #2 rst = 1'b0;
            img_m = SOLVED_W; cnt_m = '0; play_m = 1'b0;
            repeat (3) @(negedge sys_clk);
            #2 rst = 1'b1;
        end else begin
            img_m = im; cnt_m = '0; play_m = 1'b1;
            repeat (n + 2) @(negedge sys_clk);
            check("shuffle_busy_fall", 32'(busy), 32'd0);
            check("shuffle_exit_unsolved", 32'(img_nums != SOLVED_W), 32'd1);
            check("shuffle_exit_solved", 32'(solved), 32'd0);
            check("shuffle_exit_cnt", 32'(move_cnt), 32'd0);
        end
    endtask

    task automatic route_to_d();
        logic [11:0] im;
        bit          use_ccw;
        int          guard;
        im = img_m; use_ccw = 0; guard = 0;
        while (blank_m(im) != 3 && guard < 4) begin
            im = swap_m(im, blank_m(im), tgt_of(cw_dir(blank_m(im)), blank_m(im)));
            guard++;
        end
        if (im == SOLVED_W) use_ccw = 1;
        guard = 0;
        while (blank_m(img_m) != 3 && guard < 4) begin
            press(4'b1000 >> (use_ccw ? ccw_dir(blank_m(img_m)) : cw_dir(blank_m(img_m))));
            guard++;
        end
    endtask

    task automatic safe_move();
        int p, d;
        p = blank_m(img_m);
        d = cw_dir(p);
        if (swap_m(img_m, p, tgt_of(d, p)) == SOLVED_W) d = ccw_dir(p);
        press(4'b1000 >> d);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_img"},    32'(img_nums), 32'(SOLVED_W));
        check({tag, "_solved"}, 32'(solved),   32'd1);
        check({tag, "_busy"},   32'(busy),     32'd0);
        check({tag, "_cnt"},    32'(move_cnt), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;
        n_checks = 0; n_fail = 0; tag_n = '0;
        img_m = SOLVED_W; cnt_m = '0; play_m = 1'b0;
        {btn_up, btn_down, btn_left, btn_right, btn_start} = 5'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        #2 rst = 1'b1;
        repeat (20) @(negedge sys_clk);
        check_reset_vals("reset");

        press(4'b1000);
        check_reset_vals("idle_up_ignored");

        do_start(0);

        route_to_d();
        press(4'b1000);
        check("up_img", 32'(img_nums), 32'(img_m));
        check("up_cnt", 32'(move_cnt), 32'(cnt_m));
        press(4'b0100);
        press(4'b1010);
        check("prio_up_left_img", 32'(img_nums), 32'(img_m));

        @(negedge sys_clk);
        btn_left = 1'b1;
        repeat (3) @(negedge sys_clk);
        btn_left = 1'b0;
        repeat (15) @(negedge sys_clk);
        check("glitch_img", 32'(img_nums), 32'(img_m));
        check("glitch_cnt", 32'(move_cnt), 32'(cnt_m));

        press(4'b0001);
        check("illegal_right_img", 32'(img_nums), 32'(img_m));
        check("illegal_right_cnt", 32'(move_cnt), 32'(cnt_m));

        guard = 0;
        while (play_m && guard < 12) begin
            press(4'b1000 >> cw_dir(blank_m(img_m)));
            guard++;
        end
        check("win_img", 32'(img_nums), 32'(SOLVED_W));
        check("win_solved", 32'(solved), 32'd1);
        check("win_cnt", 32'(move_cnt), 32'(cnt_m));

        press(4'b1000);
        press(4'b0010);
        check("win_hold_img", 32'(img_nums), 32'(SOLVED_W));
        check("win_hold_cnt", 32'(move_cnt), 32'(cnt_m));

        do_start(0);
        safe_move();
        check("play_move_cnt", 32'(move_cnt), 32'd1);
        do_start(0);

        do_start(1);
        repeat (10) @(negedge sys_clk);
        check_reset_vals("reset_mid_shuffle");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
